// File: rtl/rv_fetch_pq_pkg.sv
// Shared constants, queue-entry type and sizing helper for the prefetch-queue
// fetch stage.
package rv_fetch_pq_pkg;

  localparam int unsigned ENTRY_W          = 64;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] INSN_BYTES       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  // Smallest r with 2**r >= value.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    while ((32'd1 << r) < value) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_fetch_pq_if.sv
// Instruction-memory request/response port of the fetch stage.
interface rv_fetch_pq_if;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic        im_stall_i;
  logic [31:0] im_data_i;
  logic        im_valid_i;

  modport master (
    output im_addr_o,
    output im_rd_o,
    input  im_stall_i,
    input  im_data_i,
    input  im_valid_i
  );

  modport slave (
    input  im_addr_o,
    input  im_rd_o,
    output im_stall_i,
    output im_data_i,
    output im_valid_i
  );
endinterface

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, ir} entries; flush outranks push and pop.
module rv_fetch_fifo
  import rv_fetch_pq_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = ENTRY_W,
  localparam int unsigned AW    = log2_ceil(DEPTH),
  localparam int unsigned CW    = log2_ceil(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy and flush.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    do_push_s = push_i & ~flush_i & ~full_s;
    do_pop_s  = pop_i & ~flush_i & ~empty_s;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_r;
  assign head_o  = mem_r[rd_ptr_r];

endmodule

// File: rtl/rv_fetch_pq_chk.sv
// Protocol and overflow checks for the prefetch-queue fetch stage.
module rv_fetch_pq_chk #(
  parameter int unsigned CW = 3
) (
  input logic          clk_i,
  input logic          rst_n_i,
  input logic          push_i,
  input logic          full_i,
  input logic          im_valid_i,
  input logic [CW-1:0] outst_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && full_i))
    else $error("rv_fetch_pq: push into a full prefetch queue");

  a_resp_has_req: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(im_valid_i && (outst_i == {CW{1'b0}})))
    else $error("rv_fetch_pq: im_valid_i with no request outstanding");

endmodule

// File: rtl/rv_fetch_pq.sv
// Prefetch-queue fetch stage: keeps up to DEPTH fetches in flight, buffers returned
// words for decode, and on a redirect flushes the queue and drains stale responses.
module rv_fetch_pq
  import rv_fetch_pq_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rv_fetch_pq_if.master im,
  input  logic          f_stall_i,
  input  logic          f_kill_i,
  output logic [31:0]   f_ir_o,
  output logic [31:0]   f_pc_o,
  output logic          f_ir_valid_o,
  input  logic          x_bra_i,
  input  logic [31:0]   x_pc_bra_i
);

  localparam int unsigned CW = log2_ceil(DEPTH) + 1;
  localparam int unsigned IW = CW + 1;

  logic [31:0]   req_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] discard_r;

  logic [CW-1:0] q_count_s;
  logic          q_full_s;
  logic          q_empty_s;
  fetch_entry_t  q_head_s;
  fetch_entry_t  q_wdata_s;
  logic [IW-1:0] inflight_s;
  logic [31:0]   addr_s;
  logic          rd_s;
  logic          acc_s;
  logic          resp_s;
  logic          push_s;
  logic          pop_s;

  // Credit, request, response qualification and queue control.
  always_comb begin
    // A redirect empties the queue this cycle, so only outstanding requests hold credit.
    inflight_s   = {1'b0, (x_bra_i ? {CW{1'b0}} : q_count_s)} + {1'b0, outst_r};
    rd_s         = rst_n_i & (inflight_s < IW'(DEPTH));
    addr_s       = x_bra_i ? x_pc_bra_i : req_pc_r;
    acc_s        = rd_s & ~im.im_stall_i;
    resp_s       = im.im_valid_i & (outst_r != {CW{1'b0}});
    push_s       = resp_s & ~x_bra_i & (discard_r == {CW{1'b0}});
    pop_s        = ~q_empty_s & ~f_stall_i & ~x_bra_i;
    q_wdata_s.pc = resp_pc_r;
    q_wdata_s.ir = im.im_data_i;
  end

  // Request-side address: advances on accept; an unaccepted redirect still retargets.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_pc_r <= RESET_VECTOR;
    end else if (acc_s) begin
      req_pc_r <= addr_s + INSN_BYTES;
    end else if (x_bra_i) begin
      req_pc_r <= x_pc_bra_i;
    end else begin
      req_pc_r <= req_pc_r;
    end
  end

  // Outstanding count, stale-response drain counter and response-side PC.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outst_r   <= {CW{1'b0}};
      discard_r <= {CW{1'b0}};
      resp_pc_r <= RESET_VECTOR;
    end else begin
      outst_r <= outst_r + CW'(acc_s) - CW'(resp_s);
      if (x_bra_i) begin
        discard_r <= outst_r - CW'(resp_s);
        resp_pc_r <= x_pc_bra_i;
      end else if (resp_s && (discard_r != {CW{1'b0}})) begin
        discard_r <= discard_r - CW'(1'b1);
      end else if (resp_s) begin
        resp_pc_r <= resp_pc_r + INSN_BYTES;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (x_bra_i),
    .wdata_i (q_wdata_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s),
    .count_o (q_count_s),
    .head_o  (q_head_s)
  );

  rv_fetch_pq_chk #(
    .CW (CW)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push_s),
    .full_i     (q_full_s),
    .im_valid_i (im.im_valid_i),
    .outst_i    (outst_r)
  );

  assign im.im_addr_o = addr_s;
  assign im.im_rd_o   = rd_s;
  assign f_ir_o       = q_head_s.ir;
  assign f_pc_o       = q_head_s.pc;
  assign f_ir_valid_o = ~q_empty_s & ~f_kill_i & ~x_bra_i;

endmodule
